// File: rtl/pipeline_monitor_pkg.sv
// Shared types and defaults for the pipeline performance monitor.
// State encodings, counter width and run length used by RTL and bench.
package pipeline_monitor_pkg;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_CYCLE_LIMIT = 64;

    localparam int N_CNT    = 4;
    localparam int IX_CYC   = 0;
    localparam int IX_STALL = 1;
    localparam int IX_FLUSH = 2;
    localparam int IX_RET   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_monitor_if.sv
// Observation bundle between the CPU side and the monitor.
// master: CPU/bench drives events and snapshot handshake; slave: monitor.
interface pipeline_monitor_if
    import pipeline_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             start_i;
    logic             stall_i;
    logic             branch_i;
    logic             flush_i;
    logic             retire_i;
    logic             snap_req_i;
    logic             snap_ack_i;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] retire_cnt_o;
    logic [CNT_W-1:0] snap_cycle_o;
    logic [CNT_W-1:0] snap_stall_o;
    logic [CNT_W-1:0] snap_flush_o;
    logic [CNT_W-1:0] snap_retire_o;
    logic             snap_valid_o;
    logic             halt_o;

    modport master (
        output start_i, stall_i, branch_i, flush_i, retire_i,
        output snap_req_i, snap_ack_i,
        input  state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o,
        input  retire_cnt_o, snap_cycle_o, snap_stall_o,
        input  snap_flush_o, snap_retire_o, snap_valid_o, halt_o
    );

    modport slave (
        input  start_i, stall_i, branch_i, flush_i, retire_i,
        input  snap_req_i, snap_ack_i,
        output state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o,
        output retire_cnt_o, snap_cycle_o, snap_stall_o,
        output snap_flush_o, snap_retire_o, snap_valid_o, halt_o
    );

endinterface

// File: rtl/pipeline_monitor_sat_counter.sv
// Saturating event counter with enable and synchronous clear.
// Ports: clk_i, clr_i, en_i; q_o = current value, nxt_o = value after this edge.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] nxt_o
);

    assign nxt_o = (en_i && !(&q_o)) ? q_o + W'(1) : q_o;

    always_ff @(posedge clk_i) begin
        if (clr_i) q_o <= '0;
        else       q_o <= nxt_o;
    end

endmodule

// File: rtl/pipeline_monitor.sv
// Pipeline performance monitor: cycle/stall/flush/retire counters + snapshot.
// Ports: clk_i, rst_i (sync, active-high), mon (slave side of the bundle).
module pipeline_monitor
    import pipeline_monitor_pkg::*;
#(
    parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipeline_monitor_if.slave  mon
);

    // Wide enough to hold CYCLE_LIMIT and any counter value without aliasing.
    localparam int XW = (CNT_W > 31) ? CNT_W + 1 : 32;

    state_t           state_q;
    state_t           state_d;
    logic             run;
    logic             lim_hit;
    logic             enter_done;
    logic             cap;
    logic [N_CNT-1:0] en;
    logic [CNT_W-1:0] cnt_q  [N_CNT];
    logic [CNT_W-1:0] cnt_d  [N_CNT];
    logic [CNT_W-1:0] snap_q [N_CNT];
    logic             snap_vld_q;
    logic             halt_q;
    logic [XW-1:0]    cyc_x;

    assign en[IX_CYC]   = run;
    assign en[IX_STALL] = run && mon.stall_i && !mon.branch_i;
    assign en[IX_FLUSH] = run && mon.flush_i;
    assign en[IX_RET]   = run && mon.retire_i;

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .clr_i (rst_i),
            .en_i  (en[g]),
            .q_o   (cnt_q[g]),
            .nxt_o (cnt_d[g])
        );
    end

    // Compare the post-edge cycle count so DONE coincides with reaching the limit.
    assign cyc_x   = XW'(cnt_d[IX_CYC]);
    assign lim_hit = (cyc_x == XW'(CYCLE_LIMIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mon.start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (lim_hit)           state_d = ST_DONE;
                else if (!mon.start_i) state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run         = (state_q == ST_RUN);
        mon.state_o = state_q;
    end

    assign enter_done = run && (state_d == ST_DONE);

    // Request is honoured when empty or when the ack frees the slot this edge.
    assign cap = (mon.snap_req_i && (!snap_vld_q || mon.snap_ack_i))
              || (enter_done && !snap_vld_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CNT; i++) snap_q[i] <= '0;
            snap_vld_q <= 1'b0;
        end else if (cap) begin
            for (int i = 0; i < N_CNT; i++) snap_q[i] <= cnt_d[i];
            snap_vld_q <= 1'b1;
        end else if (mon.snap_ack_i) begin
            snap_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)           halt_q <= 1'b0;
        else if (enter_done) halt_q <= 1'b1;
    end

    assign mon.cycle_cnt_o   = cnt_q[IX_CYC];
    assign mon.stall_cnt_o   = cnt_q[IX_STALL];
    assign mon.flush_cnt_o   = cnt_q[IX_FLUSH];
    assign mon.retire_cnt_o  = cnt_q[IX_RET];
    assign mon.snap_cycle_o  = snap_q[IX_CYC];
    assign mon.snap_stall_o  = snap_q[IX_STALL];
    assign mon.snap_flush_o  = snap_q[IX_FLUSH];
    assign mon.snap_retire_o = snap_q[IX_RET];
    assign mon.snap_valid_o  = snap_vld_q;
    assign mon.halt_o        = halt_q;

endmodule

// File: tb/tb_pipeline_monitor.sv
// Self-checking bench for pipeline_monitor: randomized and directed scenarios
// against a behavioural model of the counters, FSM and snapshot register.
module tb_pipeline_monitor;
    import pipeline_monitor_pkg::*;

    localparam int W   = DEF_CNT_W;
    localparam int LIM = DEF_CYCLE_LIMIT;
    localparam longint unsigned MAXV = (64'd1 << W) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, stall, branch, flush, retire, req, ack;

    pipeline_monitor_if #(.CNT_W(W)) mif ();
    pipeline_monitor_if #(.CNT_W(4)) mif4 ();

    assign mif.start_i     = start;
    assign mif.stall_i     = stall;
    assign mif.branch_i    = branch;
    assign mif.flush_i     = flush;
    assign mif.retire_i    = retire;
    assign mif.snap_req_i  = req;
    assign mif.snap_ack_i  = ack;
    assign mif4.start_i    = start;
    assign mif4.stall_i    = stall;
    assign mif4.branch_i   = branch;
    assign mif4.flush_i    = flush;
    assign mif4.retire_i   = retire;
    assign mif4.snap_req_i = req;
    assign mif4.snap_ack_i = ack;

    pipeline_monitor #(.CYCLE_LIMIT(LIM), .CNT_W(W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (mif)
    );

    pipeline_monitor #(.CYCLE_LIMIT(LIM), .CNT_W(4)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (mif4)
    );

    // Reference model: 0=idle 1=run 2=done; counts as plain integers.
    int              m_state;
    longint unsigned m_cnt  [4];
    longint unsigned m_snap [4];
    bit              m_valid;
    bit              m_halt;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [63:0] obs_cnt(int i);
        case (i)
            0:       return 64'(mif.cycle_cnt_o);
            1:       return 64'(mif.stall_cnt_o);
            2:       return 64'(mif.flush_cnt_o);
            default: return 64'(mif.retire_cnt_o);
        endcase
    endfunction

    function automatic logic [63:0] obs_snap(int i);
        case (i)
            0:       return 64'(mif.snap_cycle_o);
            1:       return 64'(mif.snap_stall_o);
            2:       return 64'(mif.snap_flush_o);
            default: return 64'(mif.snap_retire_o);
        endcase
    endfunction

    function automatic longint unsigned bump(longint unsigned v, bit c);
        if (c && v < MAXV) return v + 1;
        return v;
    endfunction

    // One clock edge: advance the model on the inputs the DUT sees, then settle.
    task automatic step();
        longint unsigned n [4];
        int ns;
        bit was_valid;
        @(posedge clk);
        if (rst) begin
            m_state = 0;
            m_cnt   = '{0, 0, 0, 0};
            m_snap  = '{0, 0, 0, 0};
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else begin
            n = m_cnt;
            if (m_state == 1) begin
                n[0] = bump(n[0], 1'b1);
                n[1] = bump(n[1], stall && !branch);
                n[2] = bump(n[2], flush);
                n[3] = bump(n[3], retire);
            end
            ns = m_state;
            if (m_state == 0 && start) ns = 1;
            else if (m_state == 1) ns = (n[0] == LIM) ? 2 : (start ? 1 : 0);
            was_valid = m_valid;
            if (req && (!was_valid || ack)) begin
                m_snap  = n;
                m_valid = 1'b1;
            end else if (ack) begin
                m_valid = 1'b0;
            end
            if (m_state == 1 && ns == 2) begin
                m_halt = 1'b1;
                if (!was_valid) begin
                    m_snap  = n;
                    m_valid = 1'b1;
                end
            end
            m_cnt   = n;
            m_state = ns;
        end
        #1;
    endtask

    task automatic clr_ev();
        stall = 0; branch = 0; flush = 0; retire = 0; req = 0; ack = 0;
    endtask

    task automatic do_reset();
        clr_ev();
        start = 0;
        rst   = 1;
        step();
        rst   = 0;
    endtask

    task automatic test_reset();
        start = 1; stall = 1; flush = 1; retire = 1; req = 1; ack = 0;
        branch = 0;
        rst = 1;
        step();
        step();
        n_chk++;
        if (mif.state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", mif.state_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs_cnt(i) !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_cnt%0d: got %0d want 0", i, obs_cnt(i));
            end
            n_chk++;
            if (obs_snap(i) !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_snap%0d: got %0d want 0", i, obs_snap(i));
            end
        end
        n_chk++;
        if (mif.snap_valid_o !== 1'b0 || mif.halt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b halt=%b want 0/0",
                     mif.snap_valid_o, mif.halt_o);
        end
        rst = 0;
        clr_ev();
        start = 0;
    endtask

    task automatic test_stall_branch();
        bit plain [5];
        int j;
        bit t;
        do_reset();
        start = 1;
        step();
        plain = '{1, 1, 1, 0, 0};
        for (int i = 4; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = plain[i]; plain[i] = plain[j]; plain[j] = t;
        end
        for (int i = 0; i < 5; i++) begin
            stall  = 1;
            branch = !plain[i];
            flush  = 1'($urandom % 2);
            retire = 1'($urandom % 2);
            step();
        end
        clr_ev();
        n_chk++;
        if (mif.stall_cnt_o !== W'(3)) begin
            n_fail++;
            $display("FAIL stall_branch: got %0d want 3", mif.stall_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs_cnt(i) !== m_cnt[i]) begin
                n_fail++;
                $display("FAIL stall_branch_cnt%0d: got %0d want %0d",
                         i, obs_cnt(i), m_cnt[i]);
            end
        end
    endtask

    task automatic test_concurrent();
        longint unsigned b [4];
        b = m_cnt;
        stall = 1; flush = 1; retire = 1; branch = 0;
        step();
        clr_ev();
        for (int i = 1; i < 4; i++) begin
            n_chk++;
            if (obs_cnt(i) !== b[i] + 1) begin
                n_fail++;
                $display("FAIL concurrent_cnt%0d: got %0d want %0d",
                         i, obs_cnt(i), b[i] + 1);
            end
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        start = 1;
        step();
        for (int k = 0; k < 40 && m_cnt[0] != 9; k++) step();
        req = 1;
        step();
        req = 0;
        n_chk++;
        if (mif.snap_cycle_o !== W'(10) || mif.snap_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL snap_first: got cyc=%0d v=%b want 10/1",
                     mif.snap_cycle_o, mif.snap_valid_o);
        end
        step();
        stall = 1; retire = 1; req = 1;
        step();
        clr_ev();
        n_chk++;
        if (mif.snap_cycle_o !== W'(10) || mif.snap_stall_o !== W'(0)) begin
            n_fail++;
            $display("FAIL snap_ignored: got cyc=%0d stall=%0d want 10/0",
                     mif.snap_cycle_o, mif.snap_stall_o);
        end
        for (int k = 0; k < 40 && m_cnt[0] != 20; k++) step();
        req = 1; ack = 1;
        step();
        clr_ev();
        n_chk++;
        if (mif.snap_cycle_o !== W'(21) || mif.snap_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL snap_ack_req: got cyc=%0d v=%b want 21/1",
                     mif.snap_cycle_o, mif.snap_valid_o);
        end
        ack = 1;
        step();
        n_chk++;
        if (mif.snap_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_ack: got v=%b want 0", mif.snap_valid_o);
        end
        step();
        ack = 0;
        n_chk++;
        if (mif.snap_valid_o !== 1'b0 || mif.snap_cycle_o !== W'(21)) begin
            n_fail++;
            $display("FAIL snap_idle_ack: got v=%b cyc=%0d want 0/21",
                     mif.snap_valid_o, mif.snap_cycle_o);
        end
    endtask

    task automatic test_full_run();
        do_reset();
        start = 1;
        for (int k = 0; k < 100 && mif.halt_o !== 1'b1; k++) step();
        n_chk++;
        if (mif.halt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_run_halt: got %b want 1 within 100 cycles",
                     mif.halt_o);
        end
        n_chk++;
        if (mif.cycle_cnt_o !== W'(LIM) || mif.state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL full_run_done: got cyc=%0d st=%0d want %0d/2",
                     mif.cycle_cnt_o, mif.state_o, LIM);
        end
        n_chk++;
        if (mif.snap_cycle_o !== W'(LIM) || mif.snap_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_run_snap: got cyc=%0d v=%b want %0d/1",
                     mif.snap_cycle_o, mif.snap_valid_o, LIM);
        end
        start = 0; stall = 1; retire = 1; flush = 1;
        for (int k = 0; k < 4; k++) step();
        clr_ev();
        n_chk++;
        if (mif.state_o !== 2'd2 || mif.cycle_cnt_o !== W'(LIM)
            || mif.retire_cnt_o !== W'(0) || mif.halt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: got st=%0d cyc=%0d ret=%0d h=%b",
                     mif.state_o, mif.cycle_cnt_o, mif.retire_cnt_o, mif.halt_o);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        start = 1;
        step();
        for (int i = 0; i < 20; i++) begin
            retire = 1;
            step();
            retire = 0;
            if ($urandom % 2 == 0) step();
        end
        n_chk++;
        if (mif4.retire_cnt_o !== 4'd15 || mif4.cycle_cnt_o !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate4: got ret=%0d cyc=%0d want 15/15",
                     mif4.retire_cnt_o, mif4.cycle_cnt_o);
        end
        n_chk++;
        if (mif.retire_cnt_o !== W'(20)) begin
            n_fail++;
            $display("FAIL saturate32: got ret=%0d want 20", mif.retire_cnt_o);
        end
    endtask

    task automatic test_reset_in_run();
        do_reset();
        start = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            stall  = 1'($urandom % 2);
            flush  = 1'($urandom % 2);
            retire = 1'($urandom % 2);
            step();
        end
        req = 1;
        step();
        n_chk++;
        if (mif.snap_valid_o !== 1'b1 || mif.state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b st=%0d want 1/1",
                     mif.snap_valid_o, mif.state_o);
        end
        stall = 1; flush = 1; retire = 1; ack = 1;
        rst = 1;
        step();
        rst = 0;
        clr_ev();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs_cnt(i) !== 64'd0 || obs_snap(i) !== 64'd0) begin
                n_fail++;
                $display("FAIL run_reset%0d: got cnt=%0d snap=%0d want 0/0",
                         i, obs_cnt(i), obs_snap(i));
            end
        end
        n_chk++;
        if (mif.snap_valid_o !== 1'b0 || mif.state_o !== 2'd0
            || mif.halt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL run_reset_flags: got v=%b st=%0d h=%b want 0/0/0",
                     mif.snap_valid_o, mif.state_o, mif.halt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst    = ($urandom % 100) < 2;
            start  = ($urandom % 100) < 92;
            stall  = ($urandom % 100) < 30;
            branch = ($urandom % 100) < 30;
            flush  = ($urandom % 100) < 20;
            retire = ($urandom % 100) < 50;
            req    = ($urandom % 100) < 10;
            ack    = ($urandom % 100) < 15;
            if (k == 200) rst = 1;
            step();
            n_chk++;
            if (mif.state_o !== 2'(m_state) || mif.halt_o !== m_halt
                || mif.snap_valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL rand_flags k=%0d: got st=%0d h=%b v=%b want %0d/%b/%b",
                         k, mif.state_o, mif.halt_o, mif.snap_valid_o,
                         m_state, m_halt, m_valid);
            end
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (obs_cnt(i) !== m_cnt[i]) begin
                    n_fail++;
                    $display("FAIL rand_cnt%0d k=%0d: got %0d want %0d",
                             i, k, obs_cnt(i), m_cnt[i]);
                end
                n_chk++;
                if (obs_snap(i) !== m_snap[i]) begin
                    n_fail++;
                    $display("FAIL rand_snap%0d k=%0d: got %0d want %0d",
                             i, k, obs_snap(i), m_snap[i]);
                end
            end
        end
        rst = 0;
        clr_ev();
        start = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        start = 0;
        clr_ev();
        m_state = 0;
        m_cnt   = '{0, 0, 0, 0};
        m_snap  = '{0, 0, 0, 0};
        m_valid = 1'b0;
        m_halt  = 1'b0;
        test_reset();
        test_stall_branch();
        test_concurrent();
        test_snapshot();
        test_saturate();
        test_reset_in_run();
        test_random();
        test_full_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
